ram_sp_clr: RTL and testbench

//  Parametrised single-port data memory for the 8-bit core: successor to the fixed 32x8 RAM.

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_clear_fsm.sv | 68 ++++++
 rtl/ram_sp_clr.sv | 103 ++++++++++
 tb/tb_ram_sp_clr.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the single-port data memory and its clear sequencer.
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear sequencer: sweeps every address once after reset or on request, flagging busy meanwhile.
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state_r;
  clr_state_t        next_state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_next_s;

  // State register and sweep pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Next-state logic; a request while sweeping restarts from address zero
  always_comb begin
    next_state_s = state_r;
    ptr_next_s   = ptr_r;
    case (state_r)
      ST_CLEAR: begin
        if (clear_req) begin
          ptr_next_s = {ADDR_W{1'b0}};
        end else if (ptr_r == {ADDR_W{1'b1}}) begin
          next_state_s = ST_IDLE;
          ptr_next_s   = {ADDR_W{1'b0}};
        end else begin
          ptr_next_s = ptr_r + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          next_state_s = ST_CLEAR;
          ptr_next_s   = {ADDR_W{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_CLEAR;
        ptr_next_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state_r == ST_CLEAR);
    clr_we   = (state_r == ST_CLEAR);
    clr_addr = ptr_r;
  end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port data memory with selectable read latency, read-during-write policy and
// a hardware clear sequencer that fills the array with INIT_VAL.
module ram_sp_clr
  import mem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter int                READ_LAT = 0,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  input  logic              re,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              core_we_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_din_s;
  logic              wr_err_r;

  mem_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(clear_req),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Core writes only land when idle and no clear is being requested
  always_comb begin
    core_we_s  = we & ~busy_s & ~clear_req;
    mem_we_s   = clr_we_s | core_we_s;
    mem_addr_s = clr_we_s ? clr_addr_s : addr;
    mem_din_s  = clr_we_s ? INIT_VAL : data_in;
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_din_s;
    end
  end

  // One-cycle flag for a dropped write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= we & (busy_s | clear_req);
    end
  end

  assign busy   = busy_s;
  assign wr_err = wr_err_r;

  if (READ_LAT == 0) begin : g_async_rd
    logic unused_re_s;
    assign unused_re_s = re;
    // Combinational read; the array is meaningless mid-clear so return INIT_VAL
    always_comb begin
      data_out = busy_s ? INIT_VAL : mem_r[addr];
    end
  end else if (READ_LAT == 1) begin : g_sync_rd
    logic [DATA_W-1:0] rd_r;
    // Registered read with selectable read-during-write result
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_r <= {DATA_W{1'b0}};
      end else if (re) begin
        if (busy_s) begin
          rd_r <= INIT_VAL;
        end else if ((RDW_MODE == RDW_WRITE_FIRST) && core_we_s) begin
          rd_r <= data_in;
        end else begin
          rd_r <= mem_r[addr];
        end
      end else begin
        rd_r <= rd_r;
      end
    end
    assign data_out = rd_r;
  end else begin : g_bad_lat
    $error("ram_sp_clr: READ_LAT must be 0 or 1");
    assign data_out = {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench: async, read-first and write-first 32x8 instances plus an 8x16 sweep instance.
module tb_ram_sp_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [7:0]  data_in = 8'd0;
  logic        we = 1'b0, re = 1'b0, clear_req = 1'b0;
  logic [7:0]  do0, do_rf, do_wf;
  logic        busy0, busy_rf, busy_wf, err0, err_rf, err_wf;
  logic [2:0]  addr_s = 3'd0;
  logic [15:0] din_s = 16'd0;
  logic        we_s = 1'b0, re_s = 1'b0, clr_s = 1'b0;
  logic [15:0] do_s;
  logic        busy_sw, err_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sp_clr #(.DATA_W(8), .ADDR_W(5), .READ_LAT(0), .RDW_MODE(0), .INIT_VAL(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .clear_req(clear_req), .data_out(do0), .busy(busy0), .wr_err(err0));
  ram_sp_clr #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1), .RDW_MODE(0), .INIT_VAL(8'hA5)) dut_rf (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .clear_req(clear_req), .data_out(do_rf), .busy(busy_rf), .wr_err(err_rf));
  ram_sp_clr #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1), .RDW_MODE(1), .INIT_VAL(8'hA5)) dut_wf (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .clear_req(clear_req), .data_out(do_wf), .busy(busy_wf), .wr_err(err_wf));
  ram_sp_clr #(.DATA_W(16), .ADDR_W(3), .READ_LAT(1), .RDW_MODE(1), .INIT_VAL(16'hBEEF)) dut_sw (
    .clk(clk), .rst_n(rst_n), .addr(addr_s), .data_in(din_s), .we(we_s), .re(re_s),
    .clear_req(clr_s), .data_out(do_s), .busy(busy_sw), .wr_err(err_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_b;
    step();
    step();
    checks += 4;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy0); end
    if (do_rf !== 8'h00) begin failures++; $display("FAIL reset_do_rf got=%h exp=00", do_rf); end
    if (err0 !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", err0); end
    if (busy_sw !== 1'b1) begin failures++; $display("FAIL reset_busy_sw got=%b exp=1", busy_sw); end
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_b = (k < 32);
      checks++;
      if (busy0 !== exp_b) begin failures++; $display("FAIL clear_busy k=%0d got=%b exp=%b", k, busy0, exp_b); end
      if (k <= 8) begin
        exp_b = (k < 8);
        checks++;
        if (busy_sw !== exp_b) begin failures++; $display("FAIL sweep_busy k=%0d got=%b exp=%b", k, busy_sw, exp_b); end
      end
    end
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1;
      checks++;
      if (do0 !== 8'hA5) begin failures++; $display("FAIL init_async a=%0d got=%h exp=a5", i, do0); end
      step();
      checks += 2;
      if (do_rf !== 8'hA5) begin failures++; $display("FAIL init_rf a=%0d got=%h exp=a5", i, do_rf); end
      if (do_wf !== 8'hA5) begin failures++; $display("FAIL init_wf a=%0d got=%h exp=a5", i, do_wf); end
    end
    re = 1'b0;
    re_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_s = 3'(i);
      step();
      checks++;
      if (do_s !== 16'hBEEF) begin failures++; $display("FAIL init_sweep a=%0d got=%h exp=beef", i, do_s); end
    end
    re_s = 1'b0;
  endtask

  task automatic test_async_rdw();
    addr = 5'd7; data_in = 8'h3C; we = 1'b1;
    #1;
    checks++;
    if (do0 !== 8'hA5) begin failures++; $display("FAIL async_same_cycle got=%h exp=a5", do0); end
    step();
    we = 1'b0;
    #1;
    checks += 2;
    if (do0 !== 8'h3C) begin failures++; $display("FAIL async_next_cycle got=%h exp=3c", do0); end
    if (err0 !== 1'b0) begin failures++; $display("FAIL idle_write_err got=%b exp=0", err0); end
  endtask

  task automatic test_reg_rdw();
    addr = 5'd3; data_in = 8'h55; we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0; addr = 5'd7;
    #1;
    checks += 3;
    if (do_rf !== 8'hA5) begin failures++; $display("FAIL rdw_read_first got=%h exp=a5", do_rf); end
    if (do_wf !== 8'h55) begin failures++; $display("FAIL rdw_write_first got=%h exp=55", do_wf); end
    if (do0 !== 8'h3C) begin failures++; $display("FAIL async_addr7 got=%h exp=3c", do0); end
    step();
    checks += 2;
    if (do_rf !== 8'hA5) begin failures++; $display("FAIL hold_rf got=%h exp=a5", do_rf); end
    if (do_wf !== 8'h55) begin failures++; $display("FAIL hold_wf got=%h exp=55", do_wf); end
    addr = 5'd3; re = 1'b1;
    step();
    re = 1'b0;
    checks += 2;
    if (do_rf !== 8'h55) begin failures++; $display("FAIL readback_rf got=%h exp=55", do_rf); end
    if (do_wf !== 8'h55) begin failures++; $display("FAIL readback_wf got=%h exp=55", do_wf); end
  endtask

  task automatic test_wr_err_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL req_busy got=%b exp=1", busy0); end
    repeat (9) step();
    addr = 5'd2; data_in = 8'h77; we = 1'b1;
    #1;
    checks++;
    if (do0 !== 8'hA5) begin failures++; $display("FAIL busy_read got=%h exp=a5", do0); end
    step();
    we = 1'b0;
    checks += 2;
    if (err0 !== 1'b1) begin failures++; $display("FAIL wr_err_pulse got=%b exp=1", err0); end
    if (err_rf !== 1'b1) begin failures++; $display("FAIL wr_err_pulse_rf got=%b exp=1", err_rf); end
    step();
    checks++;
    if (err0 !== 1'b0) begin failures++; $display("FAIL wr_err_single got=%b exp=0", err0); end
    repeat (20) step();
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL clear_edge31 got=%b exp=1", busy0); end
    step();
    checks++;
    if (busy0 !== 1'b0) begin failures++; $display("FAIL clear_edge32 got=%b exp=0", busy0); end
    #1;
    checks++;
    if (do0 !== 8'hA5) begin failures++; $display("FAIL dropped_word got=%h exp=a5", do0); end
    addr = 5'd3;
    #1;
    checks++;
    if (do0 !== 8'hA5) begin failures++; $display("FAIL recleared_word got=%h exp=a5", do0); end
  endtask

  task automatic test_restart();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (19) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (31) step();
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL restart_edge31 got=%b exp=1", busy0); end
    step();
    checks++;
    if (busy0 !== 1'b0) begin failures++; $display("FAIL restart_edge32 got=%b exp=0", busy0); end
    addr = 5'd4; data_in = 8'h99; we = 1'b1; clear_req = 1'b1;
    step();
    we = 1'b0; clear_req = 1'b0;
    checks += 2;
    if (err0 !== 1'b1) begin failures++; $display("FAIL req_we_err got=%b exp=1", err0); end
    if (busy0 !== 1'b1) begin failures++; $display("FAIL req_we_busy got=%b exp=1", busy0); end
    repeat (32) step();
    checks += 2;
    if (busy0 !== 1'b0) begin failures++; $display("FAIL req_we_done got=%b exp=0", busy0); end
    if (do0 !== 8'hA5) begin failures++; $display("FAIL req_we_word got=%h exp=a5", do0); end
  endtask

  task automatic test_reset_mid_clear();
    logic exp_b;
    addr = 5'd5; data_in = 8'h11; we = 1'b1;
    step();
    we = 1'b0; re = 1'b1;
    step();
    re = 1'b0;
    checks++;
    if (do_rf !== 8'h11) begin failures++; $display("FAIL pre_reset_rd got=%h exp=11", do_rf); end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL mid_rst_busy got=%b exp=1", busy0); end
    if (do_rf !== 8'h00) begin failures++; $display("FAIL mid_rst_do_rf got=%h exp=00", do_rf); end
    if (do_wf !== 8'h00) begin failures++; $display("FAIL mid_rst_do_wf got=%h exp=00", do_wf); end
    if (do_s !== 16'h0000) begin failures++; $display("FAIL mid_rst_do_s got=%h exp=0000", do_s); end
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_b = (k < 32);
      checks++;
      if (busy0 !== exp_b) begin failures++; $display("FAIL reclear_busy k=%0d got=%b exp=%b", k, busy0, exp_b); end
    end
    checks++;
    if (do0 !== 8'hA5) begin failures++; $display("FAIL reclear_word got=%h exp=a5", do0); end
  endtask

  task automatic test_sweep();
    addr_s = 3'd7; din_s = 16'h1234; we_s = 1'b1; re_s = 1'b1;
    step();
    we_s = 1'b0;
    checks++;
    if (do_s !== 16'h1234) begin failures++; $display("FAIL sweep_wf got=%h exp=1234", do_s); end
    addr_s = 3'd0;
    step();
    checks++;
    if (do_s !== 16'hBEEF) begin failures++; $display("FAIL sweep_addr0 got=%h exp=beef", do_s); end
    addr_s = 3'd7;
    step();
    re_s = 1'b0;
    checks++;
    if (do_s !== 16'h1234) begin failures++; $display("FAIL sweep_top got=%h exp=1234", do_s); end
    we_s = 1'b1; clr_s = 1'b1;
    step();
    we_s = 1'b0; clr_s = 1'b0;
    checks += 2;
    if (err_s !== 1'b1) begin failures++; $display("FAIL sweep_err got=%b exp=1", err_s); end
    if (busy_sw !== 1'b1) begin failures++; $display("FAIL sweep_busy got=%b exp=1", busy_sw); end
    repeat (8) step();
    re_s = 1'b1;
    step();
    re_s = 1'b0;
    checks += 2;
    if (busy_sw !== 1'b0) begin failures++; $display("FAIL sweep_done got=%b exp=0", busy_sw); end
    if (do_s !== 16'hBEEF) begin failures++; $display("FAIL sweep_cleared got=%h exp=beef", do_s); end
  endtask

  initial begin
    test_reset();
    test_async_rdw();
    test_reg_rdw();
    test_wr_err_clear();
    test_restart();
    test_reset_mid_clear();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
